multicycle_main_control: RTL

- Multi-cycle main control FSM.
- Fetches one 16-bit instruction per pass, decodes opcode[15:12], and sequences datapath enables over 3-5 cycles, stalling on memory.
- Sits directly upstream of the ALU control: drives aluop[2:0], which AluCont combines with instr[3:0] (func) to form aluctr.

---
 rtl/multicycle_main_control.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_main_control.sv
// Multi-cycle main control FSM for a 16-bit datapath.
// Fetches one instruction per pass, decodes opcode[15:12] and sequences the
// datapath enables. Memory states stall on mem_ready. Outputs are decoded from
// the registered state. The only exceptions are FETCH's ir_write/pc_write,
// which also require mem_ready.
// Optional: define MAIN_CTRL_TRAP_EN to send illegal opcodes to a sticky TRAP
// state and expose the trap port. Without it, an illegal opcode is a NOP.
//
// state    | meaning
// IDLE     | post-reset, all outputs 0
// FETCH    | read instruction at PC, PC += 1 when memory is ready
// DECODE   | branch target precompute, dispatch on opcode
// MEM_ADDR | effective address for lw/sw
// MEM_RD   | lw data read, waits for memory
// MEM_WB   | lw write-back (retires)
// MEM_WR   | sw data write, waits for memory (retires)
// R_EXEC   | R-type ALU operation using func
// R_WB     | R-type write-back to rd (retires)
// I_EXEC   | immediate ALU operation
// I_WB     | immediate write-back to rt (retires)
// BRANCH   | beq compare and conditional PC load (retires)
// JUMP     | PC load from jump target (retires)
// TRAP     | illegal opcode, held until reset
module multicycle_main_control #(
    parameter int OPW    = 4,
    parameter int AOPW   = 3,
    parameter int RCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OPW-1:0]    opcode,
    input  logic              mem_ready,
    input  logic              zero,
    output logic              mem_read,
    output logic              mem_write,
    output logic              iord,
    output logic              ir_write,
    output logic              pc_write,
    output logic              pc_write_cond,
    output logic [1:0]        pc_source,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [AOPW-1:0]   aluop,
    output logic              reg_write,
    output logic              reg_dst,
    output logic              mem_to_reg,
    output logic [RCNT_W-1:0] retired
`ifdef MAIN_CTRL_TRAP_EN
    ,
    output logic              trap
`endif
);

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
        R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, TRAP
    } state_t;

    localparam logic [OPW-1:0] OP_R    = OPW'(4'b0000);
    localparam logic [OPW-1:0] OP_LW   = OPW'(4'b0001);
    localparam logic [OPW-1:0] OP_SW   = OPW'(4'b0010);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(4'b0011);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(4'b0100);
    localparam logic [OPW-1:0] OP_ANDI = OPW'(4'b0101);
    localparam logic [OPW-1:0] OP_ORI  = OPW'(4'b0110);
    localparam logic [OPW-1:0] OP_SLTI = OPW'(4'b0111);
    localparam logic [OPW-1:0] OP_J    = OPW'(4'b1000);

    localparam logic [AOPW-1:0] ALU_ADD = AOPW'(3'b001);
    localparam logic [AOPW-1:0] ALU_SUB = AOPW'(3'b010);
    localparam logic [AOPW-1:0] ALU_AND = AOPW'(3'b011);
    localparam logic [AOPW-1:0] ALU_RT  = AOPW'(3'b100);
    localparam logic [AOPW-1:0] ALU_OR  = AOPW'(3'b101);
    localparam logic [AOPW-1:0] ALU_SLT = AOPW'(3'b110);

    state_t              state_q, state_d;
    logic [OPW-1:0]      opc_q, opc_d;
    logic [RCNT_W-1:0]   retired_q, retired_d;
    logic                retire;

    // zero only matters to the datapath, where it qualifies pc_write_cond
    logic unused_zero;
    assign unused_zero = zero;

    // Next state, opcode latch and retire counter
    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        retire  = 1'b0;
        case (state_q)
            IDLE:     state_d = FETCH;
            FETCH:    if (mem_ready) state_d = DECODE;
            DECODE: begin
                opc_d = opcode;
                case (opcode)
                    OP_R:                          state_d = R_EXEC;
                    OP_LW, OP_SW:                  state_d = MEM_ADDR;
                    OP_BEQ:                        state_d = BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI,
                    OP_SLTI:                       state_d = I_EXEC;
                    OP_J:                          state_d = JUMP;
`ifdef MAIN_CTRL_TRAP_EN
                    default:                       state_d = TRAP;
`else
                    default:                       state_d = FETCH;
`endif
                endcase
            end
            MEM_ADDR: state_d = (opc_q == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:   if (mem_ready) state_d = MEM_WB;
            MEM_WR: begin
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            R_EXEC:   state_d = R_WB;
            I_EXEC:   state_d = I_WB;
            MEM_WB, R_WB, I_WB, BRANCH, JUMP: begin
                retire  = 1'b1;
                state_d = FETCH;
            end
            TRAP:     state_d = TRAP;
            default:  state_d = IDLE;
        endcase
        retired_d = retired_q + RCNT_W'(retire);
    end

    // Datapath enables decoded from the current state
    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        aluop         = (state_q == IDLE) ? '0 : ALU_ADD;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            DECODE:   alu_src_b = 2'b10;
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                aluop     = ALU_RT;
            end
            R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            I_EXEC: begin
                alu_src_a = 1'b1;
                case (opc_q)
                    OP_ANDI: begin alu_src_b = 2'b11; aluop = ALU_AND; end
                    OP_ORI:  begin alu_src_b = 2'b11; aluop = ALU_OR;  end
                    OP_SLTI: begin alu_src_b = 2'b10; aluop = ALU_SLT; end
                    default: begin alu_src_b = 2'b10; aluop = ALU_ADD; end
                endcase
            end
            I_WB:     reg_write = 1'b1;
            BRANCH: begin
                alu_src_a     = 1'b1;
                aluop         = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            default: ;
        endcase
    end

    assign retired = retired_q;
`ifdef MAIN_CTRL_TRAP_EN
    assign trap = (state_q == TRAP);
`endif

    // State, latched opcode and retired counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            opc_q     <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            retired_q <= retired_d;
        end
    end

endmodule
